aes_cbc_sequencer: RTL and testbench

- Controller that configures and sequences a single-block AES-128 encrypt core in CBC mode.
- Holds key, IV and skip-count registers written over a 32-bit config bus.
- Accepts 128-bit plaintext blocks on a valid/ready stream and XORs each with the chaining value.
- Starts the core, waits for completion, returns ciphertext on an output stream and updates the chain.
- Sits between the DMA/data path and the AES core; a core watchdog reports hangs.

---
 rtl/aes_cbc_sequencer.sv | 144 ++++++++++++++
 tb/tb_aes_cbc_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cbc_sequencer.sv
// CBC-mode sequencer for a single-block AES-128 encrypt core.
// Holds key/IV/skip config, chains plaintext blocks through the core and watches for core hangs.
module aes_cbc_sequencer #(
    parameter int unsigned SKIP_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_we,
    input  logic [3:0]   cfg_addr,
    input  logic [31:0]  cfg_wdata,
    output logic         cfg_err,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic         out_ready,
    output logic [127:0] core_key,
    output logic [127:0] core_din,
    output logic         core_start,
    input  logic [127:0] core_dout,
    input  logic         core_done,
    output logic         busy,
    output logic         timeout_err
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [3:0] A_SKIP = 4'd8;
    localparam logic [3:0] A_CTRL = 4'd9;

    typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

    state_t            state;
    logic [3:0][31:0]  key_r;
    logic [3:0][31:0]  iv_r;
    logic [SKIP_W-1:0] skip_r;
    logic [127:0]      chain;
    logic [SKIP_W-1:0] skip_cnt;
    logic [TMR_W-1:0]  timer;
    logic              cfg_ok;
    logic              ctrl_go;

    // Writes are accepted only while idle and only for the ten mapped words.
    assign cfg_ok   = cfg_we && (state == IDLE) && (cfg_addr <= A_CTRL);
    assign ctrl_go  = cfg_ok && (cfg_addr == A_CTRL) && cfg_wdata[0];
    assign core_key = key_r;

    // Config registers; word 0 of each group is the most significant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r   <= '0;
            iv_r    <= '0;
            skip_r  <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                case (cfg_addr[3:2])
                    2'd0:    key_r[~cfg_addr[1:0]] <= cfg_wdata;
                    2'd1:    iv_r[~cfg_addr[1:0]]  <= cfg_wdata;
                    default: if (cfg_addr == A_SKIP) skip_r <= SKIP_W'(cfg_wdata);
                endcase
            end
        end
    end

    // Block sequencing FSM with registered handshake and core controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            chain       <= '0;
            skip_cnt    <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            core_din    <= '0;
            core_start  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (skip_cnt != '0) begin
                            out_data  <= in_data;
                            skip_cnt  <= skip_cnt - SKIP_W'(1);
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            core_din   <= in_data ^ chain;
                            core_start <= 1'b1;
                            timer      <= '0;
                            state      <= START;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                START: begin
                    timer <= timer + TMR_W'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    // Timer counts cycles since the start pulse; done wins over expiry.
                    if (core_done) begin
                        out_data  <= core_dout;
                        chain     <= core_dout;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (timer == TMR_LAST) begin
                        timeout_err <= 1'b1;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Restart happens only in IDLE; it takes precedence over a same-cycle skip decrement.
            if (ctrl_go) begin
                chain       <= iv_r;
                skip_cnt    <= skip_r;
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_cbc_sequencer.sv
// Self-checking bench for aes_cbc_sequencer: NIST CBC vectors, skip, timeout,
// backpressure, reset abort and randomized blocks against a CBC reference model.
module tb_aes_cbc_sequencer;

    localparam logic [127:0] NIST_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] NIST_IV  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] NIST_P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] NIST_P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] NIST_D1  = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] NIST_C1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] NIST_C2  = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] NIST_D2  = NIST_P2 ^ NIST_C1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_we = 1'b0;
    logic [3:0]   cfg_addr = '0;
    logic [31:0]  cfg_wdata = '0;
    logic         cfg_err;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready = 1'b0;
    logic [127:0] core_key;
    logic [127:0] core_din;
    logic         core_start;
    logic [127:0] core_dout;
    logic         core_done;
    logic         busy;
    logic         timeout_err;

    aes_cbc_sequencer #(.SKIP_W(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .core_key(core_key), .core_din(core_din), .core_start(core_start),
        .core_dout(core_dout), .core_done(core_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Stand-in for the AES core: real NIST answers for the known inputs, a keyed permutation otherwise.
    function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] x);
        if (k == NIST_KEY && x == NIST_D1) return NIST_C1;
        if (k == NIST_KEY && x == NIST_D2) return NIST_C2;
        return {x[62:0], x[127:63]} ^ k ^ 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Core responder: answers a start pulse after core_lat cycles unless hung; also issues stray dones.
    int core_lat = 3;
    bit core_hang = 1'b0;
    int done_cyc = 0;
    int stray_req_n = 0;
    int stray_done_n = 0;
    int start_cnt = 0;
    int start_cyc = 0;

    always @(negedge clk) begin
        if (core_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    initial begin
        logic [127:0] d;
        core_done = 1'b0;
        core_dout = '0;
        forever begin
            @(posedge clk); #1;
            if (stray_req_n != stray_done_n) begin
                core_dout = 128'(
                    {$urandom, $urandom, $urandom, $urandom});
                core_done = 1'b1;
                @(posedge clk); #1;
                core_done = 1'b0;
                stray_done_n++;
            end else if (core_start && !core_hang && rst_n) begin
                d = core_din;
                repeat (core_lat) begin @(posedge clk); #1; end
                core_dout = fake_aes(core_key, d);
                core_done = 1'b1;
                done_cyc  = cyc;
                @(posedge clk); #1;
                core_done = 1'b0;
            end
        end
    end

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, output logic err);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        err = cfg_err;
    endtask

    task automatic push(input logic [127:0] d, output int hs);
        int n = 0;
        while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
        chk1("push_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        hs = cyc;
    endtask

    task automatic pull(input int dly, output logic [127:0] r, output int oc);
        int n = 0;
        while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
        chk1("out_valid_seen", out_valid, 1'b1);
        oc = cyc;
        r  = out_data;
        repeat (dly) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_core_din"}, core_din, '0);
        chk1({tag, "_core_start"}, core_start, 1'b0);
        chk1({tag, "_cfg_err"}, cfg_err, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        err;
    } cfg_vec_t;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] din;
        logic [127:0] ct;
    } blk_vec_t;

    cfg_vec_t cv[11];
    blk_vec_t bv[2];

    initial begin
        logic         err;
        logic [127:0] r, d0, key_m, iv_m, chain_m, exp, p;
        int           hs, oc, sc0, n, tc, skip_m;

        cv[0]  = '{4'd0,  32'h2b7e1516, 1'b0};
        cv[1]  = '{4'd1,  32'h28aed2a6, 1'b0};
        cv[2]  = '{4'd2,  32'habf71588, 1'b0};
        cv[3]  = '{4'd3,  32'h09cf4f3c, 1'b0};
        cv[4]  = '{4'd4,  32'h00010203, 1'b0};
        cv[5]  = '{4'd5,  32'h04050607, 1'b0};
        cv[6]  = '{4'd6,  32'h08090a0b, 1'b0};
        cv[7]  = '{4'd7,  32'h0c0d0e0f, 1'b0};
        cv[8]  = '{4'd8,  32'h00000000, 1'b0};
        cv[9]  = '{4'd10, 32'hffffffff, 1'b1};
        cv[10] = '{4'd15, 32'h12345678, 1'b1};
        bv[0]  = '{NIST_P1, NIST_D1, NIST_C1};
        bv[1]  = '{NIST_P2, NIST_D2, NIST_C2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("post_reset_in_ready", in_ready, 1'b1);
        chk1("post_reset_busy", busy, 1'b0);

        // Config table, including rejected addresses
        for (int i = 0; i < 11; i++) begin
            cfg_write(cv[i].addr, cv[i].data, err);
            chk1($sformatf("cfg_err_addr%0d", cv[i].addr), err, cv[i].err);
        end
        chk("core_key_nist", core_key, NIST_KEY);
        cfg_write(4'd9, 32'h1, err);
        chk1("cfg_err_ctrl", err, 1'b0);

        // NIST CBC blocks: core input, single start pulse, ciphertext and latency
        for (int i = 0; i < 2; i++) begin
            sc0 = start_cnt;
            push(bv[i].pt, hs);
            chk1($sformatf("nist%0d_core_start", i), core_start, 1'b1);
            chk($sformatf("nist%0d_core_din", i), core_din, bv[i].din);
            pull(0, r, oc);
            chk($sformatf("nist%0d_out_data", i), r, bv[i].ct);
            chkn($sformatf("nist%0d_done_to_valid", i), oc - done_cyc, 1);
            chkn($sformatf("nist%0d_start_pulses", i), start_cnt - sc0, 1);
        end

        // Skip two passthrough blocks, then the first NIST block from a fresh IV
        cfg_write(4'd8, 32'd2, err);
        cfg_write(4'd9, 32'h1, err);
        sc0 = start_cnt;
        for (int i = 0; i < 2; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            push(p, hs);
            chk1($sformatf("skip%0d_valid_next", i), out_valid, 1'b1);
            chk1($sformatf("skip%0d_no_start", i), core_start, 1'b0);
            pull(0, r, oc);
            chk($sformatf("skip%0d_passthrough", i), r, p);
        end
        chkn("skip_start_pulses", start_cnt - sc0, 0);
        push(NIST_P1, hs);
        chk("skip_then_din", core_din, NIST_D1);
        pull(0, r, oc);
        chk("skip_then_ct", r, NIST_C1);

        // Hung core: watchdog fires 64 cycles after start, stray done ignored, restart clears
        core_hang = 1'b1;
        push(NIST_P2, hs);
        n = 0;
        while (!timeout_err && n < 200) begin @(posedge clk); #1; n++; end
        tc = cyc;
        chk1("timeout_err_set", timeout_err, 1'b1);
        chkn("timeout_latency", tc - start_cyc, 64);
        chk1("timeout_in_ready", in_ready, 1'b1);
        chk1("timeout_busy", busy, 1'b0);
        stray_req_n++;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chkn("stray_done_ignored", n, 0);
        core_hang = 1'b0;
        cfg_write(4'd8, 32'd0, err);
        cfg_write(4'd9, 32'h1, err);
        chk1("timeout_cleared", timeout_err, 1'b0);

        // Backpressure: result held, writes rejected while busy
        push(NIST_P1, hs);
        n = 0;
        while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
        d0 = out_data;
        chk("bp_data", d0, NIST_C1);
        cfg_write(4'd0, 32'hdeadbeef, err);
        chk1("bp_cfg_err", err, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk1("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_data", out_data, d0);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        chk("bp_key_unchanged", core_key, NIST_KEY);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk1("bp_released", out_valid, 1'b0);

        // Randomized configurations against a CBC reference model
        for (int c = 0; c < 4; c++) begin
            key_m = {$urandom, $urandom, $urandom, $urandom};
            iv_m  = {$urandom, $urandom, $urandom, $urandom};
            skip_m = int'($urandom_range(3, 0));
            core_lat = int'($urandom_range(8, 1));
            for (int w = 0; w < 4; w++) begin
                cfg_write(4'(w), key_m[127 - 32*w -: 32], err);
                cfg_write(4'(w + 4), iv_m[127 - 32*w -: 32], err);
            end
            cfg_write(4'd8, 32'(skip_m), err);
            cfg_write(4'd9, 32'h1, err);
            chk1("rand_cfg_ok", err, 1'b0);
            chain_m = iv_m;
            for (int b = 0; b < 10; b++) begin
                p = {$urandom, $urandom, $urandom, $urandom};
                if (skip_m != 0) begin
                    exp = p;
                    skip_m--;
                end else begin
                    chain_m = fake_aes(key_m, p ^ chain_m);
                    exp = chain_m;
                end
                push(p, hs);
                pull(int'($urandom_range(3, 0)), r, oc);
                chk($sformatf("rand_c%0d_b%0d", c, b), r, exp);
            end
        end

        // Reset during WAIT aborts; a late core_done is discarded
        core_hang = 1'b1;
        cfg_write(4'd9, 32'h1, err);
        push(NIST_P1, hs);
        repeat (5) begin @(posedge clk); #1; end
        chk1("wait_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero_outputs("abort");
        chk("abort_key", core_key, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray_req_n++;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chkn("post_abort_no_valid", n, 0);
        chk1("post_abort_in_ready", in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
